// File: rtl/otter_intr_ctrl.sv
// rtl/otter_intr_ctrl.sv - multi-source interrupt controller for the OTTER MCU
//
// Purpose: synchronizes N_SRC asynchronous interrupt lines and latches each
// rising edge as pending. It masks the pending bits per source and with a
// global enable, and drives the CU FSM INTR input through a one-in-service
// handshake.
//
// Ports:
//   clk        system clock, rising edge
//   RST_N      asynchronous active-low reset
//   src        raw asynchronous interrupt lines (edge-triggered, active high)
//   int_taken  CU FSM pulse: interrupt accepted
//   mret_exec  CU FSM pulse: MRET executed
//   cfg_we     register write strobe
//   cfg_addr   0 ENABLE, 1 PENDING (W1C), 2 CAUSE (RO), 3 CTRL (bit0 GIE)
//   cfg_wdata  register write data
//   cfg_rdata  combinational read data, unused high bits read 0
//   INTR       interrupt request to the CU FSM (a state bit)
//   in_service high while an interrupt is being serviced
module otter_intr_ctrl #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             RST_N,
  input  logic [N_SRC-1:0] src,
  input  logic             int_taken,
  input  logic             mret_exec,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  output logic             INTR,
  output logic             in_service
);

  // The encoding puts INTR and in_service directly on state bits. This keeps
  // every input off the combinational path to INTR.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic [N_SRC-1:0] s1, s2, s3;
  logic [N_SRC-1:0] pending, pending_nxt;
  logic [N_SRC-1:0] enable;
  logic             gie;
  logic [31:0]      cause;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] grant;
  logic [4:0]       sel;
  logic             req;
  logic             take;
  logic             capture;
  logic             wdata_unused;

  assign rise    = s2 & ~s3;
  assign active  = pending & enable;
  assign req     = gie & (|active);
  assign take    = (state == REQ) && int_taken;
  assign capture = take && req;

  assign wdata_unused = ^cfg_wdata[31:N_SRC];

  // Lowest active index wins. The loop scans downward so the last hit is the
  // lowest index. The grant is one-hot so the capture clear needs no variable
  // bit select.
  always_comb begin
    sel   = '0;
    grant = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        sel      = 5'(i);
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

  // Clears are applied first and the new rise is ORed in last, so a set
  // always beats a coincident W1C or capture clear.
  always_comb begin
    pending_nxt = pending;
    if (cfg_we && cfg_addr == 2'd1) begin
      pending_nxt = pending_nxt & ~cfg_wdata[N_SRC-1:0];
    end
    if (capture) begin
      pending_nxt = pending_nxt & ~grant;
    end
    pending_nxt = pending_nxt | rise;
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      s1      <= '0;
      s2      <= '0;
      s3      <= '0;
      pending <= '0;
      enable  <= '0;
      gie     <= 1'b0;
      cause   <= '0;
    end else begin
      s1      <= src;
      s2      <= s1;
      s3      <= s2;
      pending <= pending_nxt;
      if (cfg_we && cfg_addr == 2'd0) begin
        enable <= cfg_wdata[N_SRC-1:0];
      end
      if (cfg_we && cfg_addr == 2'd3) begin
        gie <= cfg_wdata[0];
      end
      // A spurious take (request withdrawn while in REQ) records CAUSE as 0.
      if (take) begin
        cause <= capture ? {1'b1, 26'd0, sel} : 32'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // REQ has no exit other than int_taken. The CU FSM may already have
  // committed to the trap, so the request cannot be withdrawn.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req)       state_nxt = REQ;
      REQ:     if (int_taken) state_nxt = SERVICE;
      SERVICE: if (mret_exec) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  assign INTR       = state[0];
  assign in_service = state[1];

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0:    cfg_rdata[N_SRC-1:0] = enable;
      2'd1:    cfg_rdata[N_SRC-1:0] = pending;
      2'd2:    cfg_rdata            = cause;
      default: cfg_rdata[0]         = gie;
    endcase
  end

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// tb/tb_otter_intr_ctrl.sv - scoreboard bench for otter_intr_ctrl
module tb_otter_intr_ctrl;

  localparam int N_SRC = 8;

  logic             clk;
  logic             RST_N;
  logic [N_SRC-1:0] src;
  logic             int_taken;
  logic             mret_exec;
  logic             cfg_we;
  logic [1:0]       cfg_addr;
  logic [31:0]      cfg_wdata;
  logic [31:0]      cfg_rdata;
  logic             INTR;
  logic             in_service;

  int tests_run;
  int tests_failed;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  otter_intr_ctrl #(.N_SRC(N_SRC)) dut (
    .clk        (clk),
    .RST_N      (RST_N),
    .src        (src),
    .int_taken  (int_taken),
    .mret_exec  (mret_exec),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata),
    .INTR       (INTR),
    .in_service (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_pop_cmp(input logic [31:0] got);
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      check(tag_q.pop_front(), got, exp_q.pop_front());
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    step(1);
    cfg_we    = 1'b0;
  endtask

  task automatic expect_reg(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    sb_push(tag, exp);
    cfg_addr = addr;
    #1;
    sb_pop_cmp(cfg_rdata);
  endtask

  task automatic expect_out(input string tag, input logic i_exp, input logic s_exp);
    sb_push({tag, "_intr"}, {31'd0, i_exp});
    sb_push({tag, "_insvc"}, {31'd0, s_exp});
    sb_pop_cmp({31'd0, INTR});
    sb_pop_cmp({31'd0, in_service});
  endtask

  task automatic pulse_take();
    int_taken = 1'b1;
    step(1);
    int_taken = 1'b0;
  endtask

  task automatic pulse_mret();
    mret_exec = 1'b1;
    step(1);
    mret_exec = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    RST_N     = 1'b0;
    src       = '0;
    int_taken = 1'b0;
    mret_exec = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = 2'd0;
    cfg_wdata = '0;
    step(2);
    RST_N = 1'b1;
    step(1);

    // 1: reset state, disabled source still latches pending
    expect_reg("rst_enable", 2'd0, 32'h0);
    expect_reg("rst_pending", 2'd1, 32'h0);
    expect_reg("rst_cause", 2'd2, 32'h0);
    expect_reg("rst_ctrl", 2'd3, 32'h0);
    expect_out("rst", 1'b0, 1'b0);
    src[3] = 1'b1;
    step(3);
    src[3] = 1'b0;
    step(2);
    expect_reg("dis_pending", 2'd1, 32'h08);
    expect_out("dis", 1'b0, 1'b0);
    wr(2'd1, 32'hFF);
    expect_reg("w1c_pending", 2'd1, 32'h0);

    // 2: source latency and a full take/return
    wr(2'd0, 32'hFF);
    wr(2'd3, 32'h1);
    expect_reg("en_readback", 2'd0, 32'hFF);
    expect_reg("ctrl_readback", 2'd3, 32'h1);
    src[5] = 1'b1;
    step(2);
    expect_reg("lat_e2_pending", 2'd1, 32'h0);
    step(1);
    expect_reg("lat_e3_pending", 2'd1, 32'h20);
    expect_out("lat_e3", 1'b0, 1'b0);
    step(1);
    expect_out("lat_e4", 1'b1, 1'b0);
    src[5] = 1'b0;
    pulse_take();
    expect_reg("t2_cause", 2'd2, 32'h8000_0005);
    expect_reg("t2_pending", 2'd1, 32'h0);
    expect_out("t2_svc", 1'b0, 1'b1);
    pulse_mret();
    expect_out("t2_ret", 1'b0, 1'b0);

    // 3: priority between two simultaneous sources
    src = 8'h44;
    step(4);
    src = '0;
    expect_out("t3_req", 1'b1, 1'b0);
    pulse_take();
    expect_reg("t3_cause1", 2'd2, 32'h8000_0002);
    expect_reg("t3_pending1", 2'd1, 32'h40);
    pulse_mret();
    expect_out("t3_ret", 1'b0, 1'b0);
    step(1);
    expect_out("t3_rereq", 1'b1, 1'b0);
    pulse_take();
    expect_reg("t3_cause2", 2'd2, 32'h8000_0006);
    expect_reg("t3_pending2", 2'd1, 32'h0);
    pulse_mret();

    // handshake pulses while IDLE are ignored
    pulse_take();
    expect_out("idle_take", 1'b0, 1'b0);
    expect_reg("idle_take_cause", 2'd2, 32'h8000_0006);
    pulse_mret();
    expect_out("idle_mret", 1'b0, 1'b0);
    expect_reg("idle_mret_cause", 2'd2, 32'h8000_0006);

    // 4: spurious take after W1C in REQ
    src[0] = 1'b1;
    step(4);
    src[0] = 1'b0;
    expect_out("t4_req", 1'b1, 1'b0);
    wr(2'd1, 32'hFF);
    expect_reg("t4_pending", 2'd1, 32'h0);
    expect_out("t4_sticky", 1'b1, 1'b0);
    pulse_take();
    expect_reg("t4_cause", 2'd2, 32'h0);
    expect_out("t4_svc", 1'b0, 1'b1);
    pulse_mret();
    step(2);
    expect_out("t4_idle", 1'b0, 1'b0);

    // 5: no nesting, then asynchronous reset mid-REQ
    src[7] = 1'b1;
    step(4);
    src[7] = 1'b0;
    pulse_take();
    expect_reg("t5_cause", 2'd2, 32'h8000_0007);
    src[1] = 1'b1;
    step(4);
    src[1] = 1'b0;
    step(2);
    expect_reg("t5_pending", 2'd1, 32'h02);
    expect_out("t5_nonest", 1'b0, 1'b1);
    pulse_mret();
    expect_out("t5_ret1", 1'b0, 1'b0);
    step(1);
    expect_out("t5_ret2", 1'b1, 1'b0);
    #2;
    RST_N = 1'b0;
    #1;
    expect_out("t5_async_rst", 1'b0, 1'b0);
    expect_reg("t5_rst_pending", 2'd1, 32'h0);
    expect_reg("t5_rst_cause", 2'd2, 32'h0);
    step(1);
    RST_N = 1'b1;
    step(1);

    // 6: same-edge W1C and rise, set wins
    src[4] = 1'b1;
    step(2);
    wr(2'd1, 32'h10);
    expect_reg("t6_setwins", 2'd1, 32'h10);
    expect_out("t6_noreq", 1'b0, 1'b0);
    src[4] = 1'b0;

    // an enable write for an already-pending source raises INTR one edge later
    wr(2'd3, 32'h1);
    wr(2'd0, 32'hFF);
    expect_out("t6_en_edge", 1'b0, 1'b0);
    step(1);
    expect_out("t6_en_next", 1'b1, 1'b0);
    pulse_take();
    expect_reg("t6_cause", 2'd2, 32'h8000_0004);
    pulse_mret();

    // new rise of the selected source on the int_taken edge keeps it pending
    src[2] = 1'b1;
    step(4);
    src[2] = 1'b0;
    expect_out("t7_req", 1'b1, 1'b0);
    step(3);
    src[2] = 1'b1;
    step(2);
    pulse_take();
    expect_reg("t7_cause", 2'd2, 32'h8000_0002);
    expect_reg("t7_pending", 2'd1, 32'h04);
    src[2] = 1'b0;
    pulse_mret();
    step(1);
    expect_out("t7_rereq", 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
